register_file_2r1w: RTL and testbench

Parametrised successor to the team's 16x8 register unit. It is a register file with two independent registered read ports and one write port. It adds:
- same-cycle write-to-read bypass
- per-entry written (valid) flags
- out-of-range detection
- a multi-cycle sweep-clear command with busy/done handshake

It sits between the datapath control FSM and the ALU operand muxes, so both operands can be fetched in one cycle.

---
 rtl/register_file_pkg.sv | 17 +
 rtl/register_read_port.sv | 71 +++++++
 rtl/register_file_2r1w.sv | 145 ++++++++++++++
 tb/tb_register_file_2r1w.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/register_file_pkg.sv
// rtl/register_file_pkg.sv - shared types and helpers for the 2-read/1-write register file
package register_file_pkg;

    // Control FSM states: normal operation or the multi-cycle sweep-clear
    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    // Address width for a given entry count; never narrower than one bit
    function automatic int addr_width(input int count);
        int w;
        w = $clog2(count);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/register_read_port.sv
// rtl/register_read_port.sv - one registered read port with range check, bypass and written-flag check
module register_read_port
    import register_file_pkg::*;
#(
    parameter int REG_COUNT  = 16,
    parameter int REG_SIZE   = 8,
    parameter int ADDR_WIDTH = addr_width(REG_COUNT)
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          rd_en,
    input  logic [ADDR_WIDTH-1:0]         rd_addr,
    input  logic                          wr_fire,
    input  logic [ADDR_WIDTH-1:0]         wr_addr,
    input  logic [REG_SIZE-1:0]           wr_data,
    input  logic [REG_COUNT*REG_SIZE-1:0] entries,
    input  logic [REG_COUNT-1:0]          written,
    output logic [REG_SIZE-1:0]           rd_data,
    output logic                          rd_valid,
    output logic                          rd_err
);

    localparam logic [ADDR_WIDTH:0] COUNT_L = (ADDR_WIDTH + 1)'(REG_COUNT);

    logic                  in_range;
    logic [ADDR_WIDTH-1:0] safe_idx;
    logic [REG_SIZE-1:0]   stored;
    logic                  stored_written;
    logic                  bypass;
    logic [REG_SIZE-1:0]   next_data;
    logic                  next_err;

    // Resolve the value a read would return this cycle: out-of-range, bypassed write, or stored entry
    always_comb begin
        in_range       = ({1'b0, rd_addr} < COUNT_L);
        // Steer out-of-range addresses to entry 0 so the array is never indexed past its end
        safe_idx       = in_range ? rd_addr : '0;
        stored         = entries[int'(safe_idx) * REG_SIZE +: REG_SIZE];
        stored_written = written[safe_idx];
        // wr_fire is already range-checked, so an address match implies an in-range read
        bypass         = wr_fire && (wr_addr == rd_addr);
        next_data      = '0;
        next_err       = 1'b1;
        if (in_range) begin
            if (bypass) begin
                next_data = wr_data;
                next_err  = 1'b0;
            end else begin
                next_data = stored;
                next_err  = ~stored_written;
            end
        end
    end

    // Output registers: data is held between reads, valid/err pulse only on a read
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
            rd_err   <= 1'b0;
        end else if (rd_en) begin
            rd_data  <= next_data;
            rd_valid <= 1'b1;
            rd_err   <= next_err;
        end else begin
            rd_valid <= 1'b0;
            rd_err   <= 1'b0;
        end
    end

endmodule

// File: rtl/register_file_2r1w.sv
// rtl/register_file_2r1w.sv - register file with two registered read ports, one write port and sweep-clear
module register_file_2r1w
    import register_file_pkg::*;
#(
    parameter int REG_COUNT  = 16,
    parameter int REG_SIZE   = 8,
    parameter int ADDR_WIDTH = addr_width(REG_COUNT)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [REG_SIZE-1:0]   wr_data,
    input  logic                  rd_en_a,
    input  logic [ADDR_WIDTH-1:0] rd_addr_a,
    output logic [REG_SIZE-1:0]   rd_data_a,
    output logic                  rd_valid_a,
    output logic                  rd_err_a,
    input  logic                  rd_en_b,
    input  logic [ADDR_WIDTH-1:0] rd_addr_b,
    output logic [REG_SIZE-1:0]   rd_data_b,
    output logic                  rd_valid_b,
    output logic                  rd_err_b,
    input  logic                  clear,
    output logic                  busy,
    output logic                  clear_done
);

    localparam logic [ADDR_WIDTH:0] COUNT_L = (ADDR_WIDTH + 1)'(REG_COUNT);
    localparam logic [ADDR_WIDTH:0] LAST_L  = COUNT_L - 1'b1;

    state_t                        state;
    logic [ADDR_WIDTH:0]           sweep_cnt;
    logic [ADDR_WIDTH-1:0]         sweep_idx;
    logic [REG_SIZE-1:0]           entries [REG_COUNT];
    logic [REG_COUNT-1:0]          written;
    logic [REG_COUNT*REG_SIZE-1:0] entries_flat;
    logic                          idle;
    logic                          wr_fire;
    logic                          rd_fire_a;
    logic                          rd_fire_b;

    // Writes and reads are only honoured outside the sweep; out-of-range writes vanish here
    always_comb begin
        idle      = (state == IDLE);
        wr_fire   = idle && wr_en && ({1'b0, wr_addr} < COUNT_L);
        rd_fire_a = idle && rd_en_a;
        rd_fire_b = idle && rd_en_b;
        sweep_idx = sweep_cnt[ADDR_WIDTH-1:0];
    end

    for (genvar i = 0; i < REG_COUNT; i++) begin : g_flat
        assign entries_flat[i*REG_SIZE +: REG_SIZE] = entries[i];
    end

    // Storage and written flags: normal writes in IDLE, one entry zeroed per cycle in CLEAR
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                entries[i] <= '0;
            end
            written <= '0;
        end else if (wr_fire) begin
            entries[wr_addr] <= wr_data;
            written[wr_addr] <= 1'b1;
        end else if (state == CLEAR) begin
            entries[sweep_idx] <= '0;
            written[sweep_idx] <= 1'b0;
        end
    end

    // Sweep FSM: counts through every entry, then pulses clear_done on the way back to IDLE
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            sweep_cnt  <= '0;
            busy       <= 1'b0;
            clear_done <= 1'b0;
        end else begin
            clear_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (clear) begin
                        state     <= CLEAR;
                        busy      <= 1'b1;
                        sweep_cnt <= '0;
                    end
                end
                CLEAR: begin
                    if (sweep_cnt == LAST_L) begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                        clear_done <= 1'b1;
                        sweep_cnt  <= '0;
                    end else begin
                        sweep_cnt <= sweep_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    register_read_port #(
        .REG_COUNT (REG_COUNT),
        .REG_SIZE  (REG_SIZE),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_port_a (
        .clock   (clock),
        .reset   (reset),
        .rd_en   (rd_fire_a),
        .rd_addr (rd_addr_a),
        .wr_fire (wr_fire),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .entries (entries_flat),
        .written (written),
        .rd_data (rd_data_a),
        .rd_valid(rd_valid_a),
        .rd_err  (rd_err_a)
    );

    register_read_port #(
        .REG_COUNT (REG_COUNT),
        .REG_SIZE  (REG_SIZE),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_port_b (
        .clock   (clock),
        .reset   (reset),
        .rd_en   (rd_fire_b),
        .rd_addr (rd_addr_b),
        .wr_fire (wr_fire),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .entries (entries_flat),
        .written (written),
        .rd_data (rd_data_b),
        .rd_valid(rd_valid_b),
        .rd_err  (rd_err_b)
    );

endmodule

// File: tb/tb_register_file_2r1w.sv
// tb/tb_register_file_2r1w.sv - randomized self-checking bench for register_file_2r1w
module tb_register_file_2r1w;

    localparam int N  = 16;
    localparam int N2 = 12;

    logic       clock = 1'b0;
    logic       reset = 1'b0;

    logic       wr_en = 1'b0;
    logic [3:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic       rd_en_a = 1'b0;
    logic [3:0] rd_addr_a = '0;
    logic [7:0] rd_data_a;
    logic       rd_valid_a;
    logic       rd_err_a;
    logic       rd_en_b = 1'b0;
    logic [3:0] rd_addr_b = '0;
    logic [7:0] rd_data_b;
    logic       rd_valid_b;
    logic       rd_err_b;
    logic       clear = 1'b0;
    logic       busy;
    logic       clear_done;

    logic       s_wr_en = 1'b0;
    logic [3:0] s_wr_addr = '0;
    logic [7:0] s_wr_data = '0;
    logic       s_rd_en_a = 1'b0;
    logic [3:0] s_rd_addr_a = '0;
    logic [7:0] s_rd_data_a;
    logic       s_rd_valid_a;
    logic       s_rd_err_a;
    logic       s_rd_en_b = 1'b0;
    logic [3:0] s_rd_addr_b = '0;
    logic [7:0] s_rd_data_b;
    logic       s_rd_valid_b;
    logic       s_rd_err_b;
    logic       s_clear = 1'b0;
    logic       s_busy;
    logic       s_clear_done;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] m_mem [N];
    logic       m_wr  [N];
    int         m_sweep;
    logic [7:0] m_data_a;
    logic [7:0] m_data_b;

    always #5 clock = ~clock;

    register_file_2r1w #(.REG_COUNT(N), .REG_SIZE(8)) dut (
        .clock(clock), .reset(reset),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a),
        .rd_valid_a(rd_valid_a), .rd_err_a(rd_err_a),
        .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b),
        .rd_valid_b(rd_valid_b), .rd_err_b(rd_err_b),
        .clear(clear), .busy(busy), .clear_done(clear_done)
    );

    register_file_2r1w #(.REG_COUNT(N2), .REG_SIZE(8)) dut12 (
        .clock(clock), .reset(reset),
        .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data),
        .rd_en_a(s_rd_en_a), .rd_addr_a(s_rd_addr_a), .rd_data_a(s_rd_data_a),
        .rd_valid_a(s_rd_valid_a), .rd_err_a(s_rd_err_a),
        .rd_en_b(s_rd_en_b), .rd_addr_b(s_rd_addr_b), .rd_data_b(s_rd_data_b),
        .rd_valid_b(s_rd_valid_b), .rd_err_b(s_rd_err_b),
        .clear(s_clear), .busy(s_busy), .clear_done(s_clear_done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_mem[i] = '0;
            m_wr[i]  = 1'b0;
        end
        m_sweep  = 0;
        m_data_a = '0;
        m_data_b = '0;
    endtask

    task automatic idle_inputs();
        wr_en = 1'b0; rd_en_a = 1'b0; rd_en_b = 1'b0; clear = 1'b0;
    endtask

    // Reference read: a read sees an in-flight write to the same entry, otherwise the stored value
    task automatic predict_port(input logic en, input logic [3:0] addr,
                                output logic v, output logic e, inout logic [7:0] d);
        v = 1'b0;
        e = 1'b0;
        if (en) begin
            v = 1'b1;
            if (int'(addr) >= N) begin
                d = '0; e = 1'b1;
            end else if (wr_en && wr_addr == addr) begin
                d = wr_data; e = 1'b0;
            end else begin
                d = m_mem[addr]; e = ~m_wr[addr];
            end
        end
    endtask

    // Advance one clock with the currently driven inputs and compare every output with the model
    task automatic step();
        logic ev_a, ee_a, ev_b, ee_b, ed;
        ev_a = 1'b0; ee_a = 1'b0; ev_b = 1'b0; ee_b = 1'b0; ed = 1'b0;
        if (m_sweep == 0) begin
            predict_port(rd_en_a, rd_addr_a, ev_a, ee_a, m_data_a);
            predict_port(rd_en_b, rd_addr_b, ev_b, ee_b, m_data_b);
            if (wr_en && int'(wr_addr) < N) begin
                m_mem[wr_addr] = wr_data;
                m_wr[wr_addr]  = 1'b1;
            end
            if (clear) m_sweep = N;
        end else begin
            m_sweep--;
            if (m_sweep == 0) begin
                ed = 1'b1;
                for (int i = 0; i < N; i++) begin
                    m_mem[i] = '0;
                    m_wr[i]  = 1'b0;
                end
            end
        end
        @(posedge clock);
        #1;
        check("valid_a", rd_valid_a, ev_a);
        check("err_a", rd_err_a, ee_a);
        check("data_a", rd_data_a, m_data_a);
        check("valid_b", rd_valid_b, ev_b);
        check("err_b", rd_err_b, ee_b);
        check("data_b", rd_data_b, m_data_b);
        check("busy", busy, m_sweep != 0);
        check("clear_done", clear_done, ed);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_data_a"}, rd_data_a, 0);
        check({tag, "_valid_a"}, rd_valid_a, 0);
        check({tag, "_err_a"}, rd_err_a, 0);
        check({tag, "_data_b"}, rd_data_b, 0);
        check({tag, "_valid_b"}, rd_valid_b, 0);
        check({tag, "_err_b"}, rd_err_b, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, clear_done, 0);
    endtask

    task automatic write(input int addr, input int data);
        idle_inputs();
        wr_en = 1'b1; wr_addr = 4'(addr); wr_data = 8'(data);
        step();
    endtask

    initial begin
        int done_seen;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        check_all_zero("in_reset");
        reset = 1'b1;

        // Out-of-range handling on a 12-entry instance
        s_wr_en = 1'b1; s_wr_addr = 4'd13; s_wr_data = 8'hFF;
        @(posedge clock); #1;
        s_wr_addr = 4'd11; s_wr_data = 8'h77;
        @(posedge clock); #1;
        s_wr_en = 1'b0;
        s_rd_en_a = 1'b1; s_rd_addr_a = 4'd13;
        s_rd_en_b = 1'b1; s_rd_addr_b = 4'd11;
        @(posedge clock); #1;
        check("oor_valid", s_rd_valid_a, 1);
        check("oor_data", s_rd_data_a, 8'h00);
        check("oor_err", s_rd_err_a, 1);
        check("inr_data", s_rd_data_b, 8'h77);
        check("inr_err", s_rd_err_b, 0);
        s_rd_addr_a = 4'd12; s_rd_addr_b = 4'd15;
        @(posedge clock); #1;
        check("edge12_err", s_rd_err_a, 1);
        check("oor15_err", s_rd_err_b, 1);
        s_rd_en_a = 1'b0; s_rd_en_b = 1'b0;

        // Read of an unwritten entry after reset
        idle_inputs();
        rd_en_a = 1'b1; rd_addr_a = 4'd3;
        step();

        // Two writes then a dual-port read, then an idle cycle
        write(2, 8'hA5);
        write(7, 8'h3C);
        idle_inputs();
        rd_en_a = 1'b1; rd_addr_a = 4'd2; rd_en_b = 1'b1; rd_addr_b = 4'd7;
        step();
        idle_inputs();
        step();

        // Bypass: both ports read the entry being written this cycle
        write(4, 8'h11);
        idle_inputs();
        wr_en = 1'b1; wr_addr = 4'd4; wr_data = 8'h5A;
        rd_en_a = 1'b1; rd_addr_a = 4'd4; rd_en_b = 1'b1; rd_addr_b = 4'd4;
        step();

        // Asynchronous reset mid-run clears outputs without a clock edge
        idle_inputs();
        rd_en_a = 1'b1; rd_addr_a = 4'd2;
        step();
        idle_inputs();
        #1 reset = 1'b0;
        #1 check_all_zero("async_rst");
        @(posedge clock); #1;
        reset = 1'b1;
        model_reset();

        // Fill every entry, then sweep-clear while hammering writes, reads and clear
        for (int i = 0; i < N; i++) write(i, $urandom_range(255, 0));
        idle_inputs();
        clear = 1'b1;
        rd_en_b = 1'b1; rd_addr_b = 4'd9;
        step();
        done_seen = 0;
        for (int i = 0; i < N + 2; i++) begin
            wr_en = 1'b1; wr_addr = 4'($urandom_range(15, 0)); wr_data = 8'($urandom);
            rd_en_a = 1'b1; rd_addr_a = 4'($urandom_range(15, 0));
            rd_en_b = 1'b1; rd_addr_b = 4'($urandom_range(15, 0));
            clear = (i < N - 1) ? 1'b1 : 1'b0;
            if (i >= N - 1) begin
                wr_en = 1'b0; rd_en_a = 1'b0; rd_en_b = 1'b0;
            end
            step();
            if (clear_done) done_seen++;
        end
        check("done_count", done_seen, 1);
        idle_inputs();
        rd_en_a = 1'b1; rd_addr_a = 4'd0;
        step();

        // Randomized traffic including occasional clears
        for (int i = 0; i < 400; i++) begin
            wr_en   = 1'($urandom_range(1, 0));
            wr_addr = 4'($urandom_range(15, 0));
            wr_data = 8'($urandom);
            rd_en_a = 1'($urandom_range(1, 0));
            rd_addr_a = ($urandom_range(3, 0) == 0) ? wr_addr : 4'($urandom_range(15, 0));
            rd_en_b = 1'($urandom_range(1, 0));
            rd_addr_b = ($urandom_range(3, 0) == 0) ? rd_addr_a : 4'($urandom_range(15, 0));
            clear   = ($urandom_range(49, 0) == 0);
            step();
        end
        idle_inputs();
        while (m_sweep != 0) step();

        // Reset in the middle of a sweep aborts it with no clear_done
        write(15, 8'h9C);
        idle_inputs();
        clear = 1'b1;
        step();
        idle_inputs();
        repeat (5) step();
        #1 reset = 1'b0;
        #1 check_all_zero("sweep_rst");
        @(posedge clock); #1;
        reset = 1'b1;
        model_reset();
        step();
        step();
        rd_en_a = 1'b1; rd_addr_a = 4'd15;
        step();
        idle_inputs();
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
